// File: rtl/pb_irq_controller.sv
// Eight-source edge-latching interrupt controller on the Picoblaze port bus.
// Latency: source edge to interrupt 2 clk, register reads 1 clk; port bus has no backpressure.
module pb_irq_controller #(
  parameter logic [7:0] BASE_ADDRESS = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] data_in,
  input  logic       read_strobe,
  input  logic       write_strobe,
  input  logic [7:0] irq_src,
  input  logic       interrupt_ack,
  output logic [7:0] data_out,
  output logic       interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pending, pending_nxt;
  logic [7:0] mask;
  logic [7:0] prev;
  logic [7:0] offset;
  logic       in_win;
  logic       wr_pend, wr_mask, wr_force, wr_eoi;
  logic [7:0] edges, masked, cur_id;
  logic       active;

  // Reads have no side effects, so the strobe is deliberately ignored.
  logic unused_rd;
  assign unused_rd = read_strobe;

  function automatic logic [7:0] lowest_id(input logic [7:0] v);
    lowest_id = 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_id = i[7:0];
    end
  endfunction

  // Subtraction keeps the decode correct for unaligned base addresses.
  assign offset   = port_id - BASE_ADDRESS;
  assign in_win   = (offset[7:2] == 6'd0);
  assign wr_pend  = write_strobe && in_win && (offset[1:0] == 2'd0);
  assign wr_mask  = write_strobe && in_win && (offset[1:0] == 2'd1);
  assign wr_force = write_strobe && in_win && (offset[1:0] == 2'd2);
  assign wr_eoi   = write_strobe && in_win && (offset[1:0] == 2'd3);

  assign edges  = irq_src & ~prev;
  assign masked = pending & mask;
  assign active = |masked;
  assign cur_id = lowest_id(masked);

  // Sets are OR-ed in after the clear so a same-cycle set wins.
  always_comb begin
    pending_nxt = pending;
    if (wr_pend) pending_nxt = pending_nxt & ~data_in;
    pending_nxt = pending_nxt | edges;
    if (wr_force) pending_nxt = pending_nxt | data_in;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (active) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (interrupt_ack) state_nxt = ST_SERVICE;
        else if (!active)  state_nxt = ST_IDLE;
      end
      ST_SERVICE: begin
        if (wr_eoi) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
    end else begin
      state     <= state_nxt;
      interrupt <= (state_nxt == ST_REQ);
    end
  end

  // prev resets high so lines already asserted at reset release are not edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 8'h00;
      mask    <= 8'h00;
      prev    <= 8'hFF;
    end else begin
      pending <= pending_nxt;
      prev    <= irq_src;
      if (wr_mask) mask <= data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out <= 8'h00;
    end else if (!in_win) begin
      data_out <= 8'h00;
    end else begin
      case (offset[1:0])
        2'd0:    data_out <= pending;
        2'd1:    data_out <= mask;
        2'd2:    data_out <= 8'h00;
        default: data_out <= cur_id;
      endcase
    end
  end

endmodule

// File: tb/tb_pb_irq_controller.sv
// Directed bench for pb_irq_controller; inputs driven and outputs sampled on the falling edge.
module tb_pb_irq_controller;

  localparam logic [7:0] BASE = 8'h20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_id;
  logic [7:0] data_in;
  logic       read_strobe;
  logic       write_strobe;
  logic [7:0] irq_src;
  logic       interrupt_ack;
  logic [7:0] data_out;
  logic       interrupt;

  int n_vec = 0;
  int n_err = 0;

  pb_irq_controller #(.BASE_ADDRESS(BASE)) dut (
    .clk           (clk),
    .reset         (reset),
    .port_id       (port_id),
    .data_in       (data_in),
    .read_strobe   (read_strobe),
    .write_strobe  (write_strobe),
    .irq_src       (irq_src),
    .interrupt_ack (interrupt_ack),
    .data_out      (data_out),
    .interrupt     (interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns one cycle later with the write applied.
  task automatic port_wr(input logic [7:0] addr, input logic [7:0] dat);
    port_id      = addr;
    data_in      = dat;
    write_strobe = 1'b1;
    @(negedge clk);
    write_strobe = 1'b0;
    data_in      = 8'h00;
  endtask

  task automatic port_rd(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    port_id     = addr;
    read_strobe = 1'b1;
    @(negedge clk);
    read_strobe = 1'b0;
    check(tag, data_out, exp);
  endtask

  task automatic irq_is(input string tag, input logic exp);
    check(tag, {7'd0, interrupt}, {7'd0, exp});
  endtask

  initial begin
    reset = 1'b1; port_id = BASE; data_in = 8'h00; read_strobe = 1'b0;
    write_strobe = 1'b0; irq_src = 8'h01; interrupt_ack = 1'b0;
    #12;
    irq_is("rst_irq", 1'b0);
    check("rst_dout", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Line held high through reset release must not register as an edge.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_pend", data_out, 8'h00);
      irq_is("hold_irq", 1'b0);
    end
    irq_src = 8'h00;
    @(negedge clk);

    // Basic request / ack / ID / W1C / EOI flow.
    port_wr(BASE + 8'd1, 8'h01);
    irq_src = 8'h01;
    @(negedge clk);
    irq_src = 8'h00;
    irq_is("lat_1clk", 1'b0);
    @(negedge clk);
    irq_is("lat_2clk", 1'b1);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    irq_is("ack_drop", 1'b0);
    port_rd("id_src0", BASE + 8'd3, 8'h00);
    irq_is("svc_quiet", 1'b0);
    port_wr(BASE, 8'h01);
    port_wr(BASE + 8'd3, 8'h00);
    @(negedge clk);
    irq_is("eoi_idle", 1'b0);
    port_rd("pend_clr", BASE, 8'h00);

    // FORCE re-raises the request, proving the FSM left SERVICE.
    port_wr(BASE + 8'd2, 8'h01);
    irq_is("force_1clk", 1'b0);
    @(negedge clk);
    irq_is("force_req", 1'b1);

    // Mask withdrawal while in REQ.
    port_wr(BASE + 8'd1, 8'h00);
    @(negedge clk);
    irq_is("mask_wd", 1'b0);
    port_rd("mask_wd_pend", BASE, 8'h01);
    port_wr(BASE + 8'd1, 8'h01);
    @(negedge clk);
    irq_is("wd_was_idle", 1'b1);
    port_wr(BASE + 8'd1, 8'h00);
    port_wr(BASE, 8'h01);

    // Priority ID ordering.
    port_wr(BASE + 8'd1, 8'h0C);
    port_wr(BASE + 8'd2, 8'h0C);
    port_rd("id_2", BASE + 8'd3, 8'h02);
    port_wr(BASE, 8'h04);
    port_rd("id_3", BASE + 8'd3, 8'h03);
    port_wr(BASE, 8'h08);
    port_rd("id_none", BASE + 8'd3, 8'hFF);
    @(negedge clk);
    irq_is("none_irq", 1'b0);

    // Set beats W1C on the same bit in the same cycle.
    irq_src = 8'h02;
    port_wr(BASE, 8'h02);
    port_rd("set_wins", BASE, 8'h02);
    irq_src = 8'h00;
    port_wr(BASE, 8'h02);
    port_rd("set_wins_clr", BASE, 8'h00);

    // Address decode.
    port_wr(BASE + 8'd2, 8'h80);
    port_rd("out_of_win", 8'h10, 8'h00);
    port_rd("force_rd", BASE + 8'd2, 8'h00);
    port_rd("pend_80", BASE, 8'h80);
    port_wr(BASE + 8'd2, 8'h00);
    port_wr(BASE + 8'd4, 8'hFF);
    port_wr(BASE - 8'd1, 8'hFF);
    port_rd("noop_pend", BASE, 8'h80);
    port_rd("noop_mask", BASE + 8'd1, 8'h0C);
    irq_is("noop_irq", 1'b0);

    // Asynchronous reset while in SERVICE.
    port_wr(BASE + 8'd1, 8'h80);
    @(negedge clk);
    irq_is("src7_req", 1'b1);
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    irq_is("src7_ack", 1'b0);
    port_rd("pre_rst_mask", BASE + 8'd1, 8'h80);
    #2 reset = 1'b1;
    #1;
    irq_is("async_irq", 1'b0);
    check("async_dout", data_out, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    port_rd("post_mask", BASE + 8'd1, 8'h00);
    port_rd("post_pend", BASE, 8'h00);
    port_rd("post_id", BASE + 8'd3, 8'hFF);
    irq_is("post_irq", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pb_irq_controller.md
# pb_irq_controller

Eight-input interrupt controller on the Picoblaze port bus, sitting directly upstream of the CPU `interrupt` input. Peripheral interrupt lines (`pb_timer` and future blocks) feed it. It latches rising edges into a pending register, applies a software mask, and drives a single interrupt request held until `interrupt_ack`. Software reads the highest-priority source ID and signals end-of-interrupt over the port bus. `data_out` is zero when not addressed, so it ORs directly into `in_port`.

## Interface
- `BASE_ADDRESS`, default 8'h20: base of a 4-byte port window (BASE+0..BASE+3).
- `clk`  in  1: system clock (CLK_OUT); the only clock.
- `reset`  in  1: asynchronous, active-high reset.
- `port_id`  in  8: Picoblaze port address.
- `data_in`  in  8: Picoblaze `out_port`.
- `read_strobe`  in  1: Picoblaze read strobe; has no side effects in this block.
- `write_strobe`  in  1: Picoblaze write strobe.
- `irq_src`  in  8: interrupt sources, synchronous to `clk`, rising-edge sensitive.
- `interrupt_ack`  in  1: CPU acknowledge, one-cycle pulse.
- `data_out`  out  8: registered read data; 0 when `port_id` is outside the window.
- `interrupt`  out  1: request to the CPU.

## Operation
- Registers:
  - BASE+0 PENDING: read returns pending[7:0]. Write clears each bit written as 1 (write-1-to-clear).
  - BASE+1 MASK: read/write enable mask. Reset value 8'h00.
  - BASE+2 FORCE: write sets pending bits written as 1 (software test). Reads return 8'h00.
  - BASE+3 ID/EOI: read returns the index (0–7) of the lowest-numbered set bit of pending&mask, or 8'hFF if none. Any write is end-of-interrupt (EOI).
- Edge detect: `prev` register samples `irq_src` every cycle. A bit sets when irq_src=1 and prev=0. `prev` resets to 8'hFF, so a line already high at reset release is not an edge.
- Pending bits latch regardless of mask. The mask gates only request generation and ID.
- Per-bit pending next-state priority, highest first: edge or FORCE sets; W1C clears; otherwise hold. Set wins when a set and a clear hit the same bit in the same cycle.
- FSM, with `active` = |(pending & mask):
  - IDLE, interrupt=0: goes to REQ when `active`=1.
  - REQ, interrupt=1:
    - `interrupt_ack`=1 → SERVICE.
    - else `active`=0 (mask or clear withdrew the request) → IDLE.
  - SERVICE, interrupt=0: EOI write → IDLE. Stays in SERVICE if `active` remains 1; nested requests are ignored until EOI.
- EOI write in IDLE or REQ: ignored.
- A write to an unused address or outside the window has no effect.

## Timing
- Reset values:
  - `interrupt`=0, `data_out`=8'h00.
  - pending=0, mask=0, prev=8'hFF, FSM=IDLE.
- Pending bit updates at the first clock edge where the edge is visible: cycle N irq_src rises, pending set after edge N.
- `interrupt` is registered. It rises 1 cycle after `active` first becomes 1, and falls the cycle after `interrupt_ack` is sampled.
- Source-edge-to-interrupt latency: 2 clocks.
- `data_out` updates every clock from the current `port_id` and register state, independent of `read_strobe`. It is valid one cycle after `port_id` changes, which meets the KCPSM6 two-cycle input timing.
- Register writes take effect on the clock edge where `write_strobe`=1. A readback in the following cycle shows the new value.
- `interrupt_ack` and EOI in the same cycle while in REQ: go to SERVICE; the EOI is ignored.
- Reset asserted in any state clears everything immediately, asynchronously; `interrupt` drops without waiting for a clock.

## Test plan
- Reset release with irq_src=8'h01 held high → pending reads 8'h00 and `interrupt`=0 for 10 cycles.
- MASK=8'h01; pulse irq_src[0] for one cycle → `interrupt`=1 two cycles later. Pulse `interrupt_ack` → `interrupt`=0 next cycle. ID reads 8'h00. Write PENDING=8'h01, then EOI → FSM back in IDLE, `interrupt` stays 0.
- MASK=8'h0C; FORCE=8'h0C → ID reads 8'h02. W1C 8'h04 → ID reads 8'h03. W1C 8'h08 → ID reads 8'hFF.
- In REQ, write MASK=8'h00 before any ack → `interrupt`=0 next cycle, FSM in IDLE, and PENDING still reads the latched bit.
- Same cycle: W1C 8'h02 and an irq_src[1] rising edge → PENDING reads 8'h02 (set wins).
- Address decode:
  - port_id=8'h10 → `data_out`=8'h00.
  - Write to BASE+2 with data 8'h00 → no state change.
  - Assert reset while in SERVICE → `interrupt` and `data_out` are 0 and MASK reads 8'h00 after release.
